// File: rtl/updn_pkg.sv
// rtl/updn_pkg.sv - shared constants and helpers for the DE2-115 up/down counter demos
package updn_pkg;

   // Board defaults: CLOCK_50 cycles per ~10 Hz / ~2 Hz tick, LEDR bank width
   localparam int DE2_DIV_FAST = 5_000_000;
   localparam int DE2_DIV_SLOW = 25_000_000;
   localparam int DE2_LEDR_W   = 18;

   // Limit a value to the count range 0..modulus-1
   function automatic logic [31:0] clamp_mod(input logic [31:0] value,
                                             input logic [31:0] modulus);
      return (value > modulus - 32'd1) ? (modulus - 32'd1) : value;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - two-speed tick divider, one-cycle tick per period
module tick_divider #(
   parameter int DIV_W    = 26,
   parameter int DIV_FAST = 5_000_000,
   parameter int DIV_SLOW = 25_000_000
) (
   input  logic CLOCK_50,
   input  logic RESET,
   input  logic fast,
   input  logic clr,
   output logic tick
);

   localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
   localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);

   logic [DIV_W-1:0] div_cnt;

   // >= rather than == so a slow-to-fast switch mid-period ticks at once instead of overrunning
   assign tick = (div_cnt >= (fast ? FAST_LAST : SLOW_LAST));

   // Period counter: restarts on every tick and on an external clear
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         div_cnt <= '0;
      end else if (clr || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/modulo_updown_counter.sv
// rtl/modulo_updown_counter.sv - modulo up/down counter with wrap/saturate, load and tc; UPDN_CNT_BOUNCE_EN selects bounce at limits
module modulo_updown_counter
   import updn_pkg::*;
#(
   parameter int WIDTH    = DE2_LEDR_W,
   parameter int MODULUS  = 2**18,
   parameter int DIV_W    = 26,
   parameter int DIV_FAST = DE2_DIV_FAST,
   parameter int DIV_SLOW = DE2_DIV_SLOW
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic             run,
   input  logic             dir_up,
   input  logic             fast,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             tick_out
);

   // One extra bit so MODULUS == 2**WIDTH still yields an exact top value
   localparam logic [WIDTH:0]   LAST_EXT = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] LAST     = LAST_EXT[WIDTH-1:0];

   logic             tick;
   logic             step;
   logic             up;
   logic             at_limit;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_clamped;

   tick_divider #(
      .DIV_W    (DIV_W),
      .DIV_FAST (DIV_FAST),
      .DIV_SLOW (DIV_SLOW)
   ) u_div (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .fast     (fast),
      .clr      (load),
      .tick     (tick)
   );

   assign load_clamped = WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));
   assign step         = run && tick && !load;
   assign at_limit     = up ? ({1'b0, count} == LAST_EXT) : (count == '0);

`ifdef UPDN_CNT_BOUNCE_EN
   logic dir_reg;
   logic dir_up_q;
   logic unused_sat_mode;

   assign unused_sat_mode = sat_mode;
   assign up              = dir_reg;

   // Direction follows switch edges; otherwise it flips whenever a step hits a limit
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         dir_reg  <= 1'b1;
         dir_up_q <= 1'b1;
      end else begin
         dir_up_q <= dir_up;
         if (dir_up != dir_up_q) begin
            dir_reg <= dir_up;
         end else if (step && at_limit) begin
            dir_reg <= ~dir_reg;
         end
      end
   end
`else
   assign up = dir_up;
`endif

   // Value the count takes if a step happens this cycle
   always_comb begin
      step_val = count;
      if (up) begin
         if (!at_limit) begin
            step_val = count + 1'b1;
         end else begin
`ifdef UPDN_CNT_BOUNCE_EN
            step_val = count - 1'b1;
`else
            if (!sat_mode) step_val = '0;
`endif
         end
      end else begin
         if (!at_limit) begin
            step_val = count - 1'b1;
         end else begin
`ifdef UPDN_CNT_BOUNCE_EN
            step_val = count + 1'b1;
`else
            if (!sat_mode) step_val = LAST;
`endif
         end
      end
   end

   // Count, terminal-count pulse and registered tick; load outranks a step
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         count    <= '0;
         tc       <= 1'b0;
         tick_out <= 1'b0;
      end else begin
         tick_out <= tick;
         tc       <= step && at_limit;
         if (load) begin
            count <= load_clamped;
         end else if (step) begin
            count <= step_val;
         end
      end
   end

endmodule

// File: tb/tb_modulo_updown_counter.sv
// tb/tb_modulo_updown_counter.sv - directed self-checking bench for modulo_updown_counter
module tb_modulo_updown_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       dir_up;
   logic       fast;
   logic       sat_mode;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;
   logic       tick_out;

   int tests = 0;
   int fails = 0;

   modulo_updown_counter #(
      .WIDTH    (4),
      .MODULUS  (10),
      .DIV_W    (4),
      .DIV_FAST (2),
      .DIV_SLOW (5)
   ) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .run      (run),
      .dir_up   (dir_up),
      .fast     (fast),
      .sat_mode (sat_mode),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .tick_out (tick_out)
   );

   always #5 clk = ~clk;

   // Apply a one-cycle load; returns at the falling edge after the loading edge
   task automatic do_load(input logic [3:0] v);
      @(negedge clk);
      load = 1'b1;
      load_val = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; run = 1'b0; dir_up = 1'b1; fast = 1'b1; sat_mode = 1'b0;
      load = 1'b0; load_val = '0;
      repeat (3) @(negedge clk);
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
      tests++; if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc: got %0b expected 0", tc); end
      tests++; if (tick_out !== 1'b0) begin fails++; $display("FAIL reset_tick_out: got %0b expected 0", tick_out); end
      rst = 1'b0;
      run = 1'b1;
      do_load(4'd6);
      @(negedge clk);
      @(negedge clk);
      tests++; if (count !== 4'd7) begin fails++; $display("FAIL pre_reset_count: got %0d expected 7", count); end
      tests++; if (tick_out !== 1'b1) begin fails++; $display("FAIL pre_reset_tick: got %0b expected 1", tick_out); end
      #2 rst = 1'b1;
      #1;
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL async_reset_count: got %0d expected 0", count); end
      tests++; if (tick_out !== 1'b0) begin fails++; $display("FAIL async_reset_tick: got %0b expected 0", tick_out); end
      tests++; if (tc !== 1'b0) begin fails++; $display("FAIL async_reset_tc: got %0b expected 0", tc); end
      @(negedge clk);
      rst = 1'b0;
      fast = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL resume_early: got %0d expected 0", count); end
      @(negedge clk);
      tests++; if (count !== 4'd1) begin fails++; $display("FAIL resume_step: got %0d expected 1", count); end
      tests++; if (tick_out !== 1'b1) begin fails++; $display("FAIL resume_tick: got %0b expected 1", tick_out); end
   endtask

   task automatic test_wrap_up;
      run = 1'b1; dir_up = 1'b1; sat_mode = 1'b0; fast = 1'b1;
      do_load(4'd8);
      @(negedge clk);
      tests++; if (count !== 4'd8) begin fails++; $display("FAIL wrap_up_hold: got %0d expected 8", count); end
      @(negedge clk);
      tests++; if (count !== 4'd9 || tc !== 1'b0) begin fails++; $display("FAIL wrap_up_8to9: got count=%0d tc=%0b expected 9/0", count, tc); end
      tests++; if (tick_out !== 1'b1) begin fails++; $display("FAIL wrap_up_tick: got %0b expected 1", tick_out); end
      @(negedge clk);
      tests++; if (tick_out !== 1'b0 || tc !== 1'b0) begin fails++; $display("FAIL wrap_up_gap: got tick=%0b tc=%0b expected 0/0", tick_out, tc); end
      @(negedge clk);
      tests++; if (count !== 4'd0 || tc !== 1'b1) begin fails++; $display("FAIL wrap_up_9to0: got count=%0d tc=%0b expected 0/1", count, tc); end
      @(negedge clk);
      tests++; if (tc !== 1'b0) begin fails++; $display("FAIL wrap_up_tc_pulse: got %0b expected 0", tc); end
   endtask

   task automatic test_wrap_down;
      run = 1'b1; dir_up = 1'b0; sat_mode = 1'b0; fast = 1'b1;
      do_load(4'd0);
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd9 || tc !== 1'b1) begin fails++; $display("FAIL wrap_down_0to9: got count=%0d tc=%0b expected 9/1", count, tc); end
   endtask

   task automatic test_sat_down;
      run = 1'b1; dir_up = 1'b0; sat_mode = 1'b1; fast = 1'b1;
      do_load(4'd1);
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd0 || tc !== 1'b0) begin fails++; $display("FAIL sat_down_1to0: got count=%0d tc=%0b expected 0/0", count, tc); end
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd0 || tc !== 1'b1) begin fails++; $display("FAIL sat_down_hold1: got count=%0d tc=%0b expected 0/1", count, tc); end
      @(negedge clk);
      tests++; if (tc !== 1'b0) begin fails++; $display("FAIL sat_down_gap: got %0b expected 0", tc); end
      @(negedge clk);
      tests++; if (count !== 4'd0 || tc !== 1'b1) begin fails++; $display("FAIL sat_down_hold2: got count=%0d tc=%0b expected 0/1", count, tc); end
   endtask

   task automatic test_load_on_tick;
      run = 1'b1; dir_up = 1'b1; sat_mode = 1'b0; fast = 1'b1;
      do_load(4'd3);
      load = 1'b1;
      load_val = 4'd13;
      @(negedge clk);
      load = 1'b0;
      tests++; if (count !== 4'd9 || tc !== 1'b0) begin fails++; $display("FAIL load_clamp: got count=%0d tc=%0b expected 9/0", count, tc); end
      @(negedge clk);
      tests++; if (count !== 4'd9) begin fails++; $display("FAIL load_restart: got %0d expected 9", count); end
      @(negedge clk);
      tests++; if (count !== 4'd0 || tc !== 1'b1) begin fails++; $display("FAIL load_then_wrap: got count=%0d tc=%0b expected 0/1", count, tc); end
   endtask

   task automatic test_fast_switch;
      run = 1'b0; dir_up = 1'b1; sat_mode = 1'b0; fast = 1'b0;
      do_load(4'd5);
      repeat (3) @(negedge clk);
      tests++; if (tick_out !== 1'b0) begin fails++; $display("FAIL switch_pre: got %0b expected 0", tick_out); end
      fast = 1'b1;
      @(negedge clk);
      tests++; if (tick_out !== 1'b1) begin fails++; $display("FAIL switch_immediate: got %0b expected 1", tick_out); end
      @(negedge clk);
      tests++; if (tick_out !== 1'b0) begin fails++; $display("FAIL switch_gap: got %0b expected 0", tick_out); end
      @(negedge clk);
      tests++; if (tick_out !== 1'b1) begin fails++; $display("FAIL switch_period: got %0b expected 1", tick_out); end
      tests++; if (count !== 4'd5 || tc !== 1'b0) begin fails++; $display("FAIL run0_hold: got count=%0d tc=%0b expected 5/0", count, tc); end
   endtask

`ifdef UPDN_CNT_BOUNCE_EN
   task automatic test_bounce;
      run = 1'b1; dir_up = 1'b1; sat_mode = 1'b0; fast = 1'b1;
      do_load(4'd8);
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd9 || tc !== 1'b0) begin fails++; $display("FAIL bounce_8to9: got count=%0d tc=%0b expected 9/0", count, tc); end
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd8 || tc !== 1'b1) begin fails++; $display("FAIL bounce_9to8: got count=%0d tc=%0b expected 8/1", count, tc); end
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd7 || tc !== 1'b0) begin fails++; $display("FAIL bounce_8to7: got count=%0d tc=%0b expected 7/0", count, tc); end
      run = 1'b0;
      dir_up = 1'b0;
      @(negedge clk);
      dir_up = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b1;
      do_load(4'd7);
      repeat (2) @(negedge clk);
      tests++; if (count !== 4'd8) begin fails++; $display("FAIL bounce_dir_reload: got %0d expected 8", count); end
   endtask
`endif

   initial begin
      test_reset;
      test_wrap_up;
      test_wrap_down;
      test_sat_down;
      test_load_on_tick;
      test_fast_switch;
`ifdef UPDN_CNT_BOUNCE_EN
      test_bounce;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
